// File: rtl/ysyx_25060173_ctrl_pkg.sv
// Shared types and constants for the NPC multi-cycle sequencing controller.
// State encoding and halt-reason codes are used by the controller and its testbench.
package ysyx_25060173_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_IF   = 3'd1,
        S_ID   = 3'd2,
        S_EX   = 3'd3,
        S_MEM  = 3'd4,
        S_WB   = 3'd5,
        S_HALT = 3'd6
    } state_e;

    localparam logic [1:0] HALT_NONE    = 2'b00;
    localparam logic [1:0] HALT_EBREAK  = 2'b01;
    localparam logic [1:0] HALT_ILLEGAL = 2'b10;
    localparam logic [1:0] HALT_TIMEOUT = 2'b11;

endpackage

// File: rtl/ysyx_25060173_perf_counters.sv
// Cycle and retired-instruction counters; both wrap modulo 2^CNT_W.
// cycle_cnt runs while run_en is high, instret_cnt steps once per retire pulse.
module ysyx_25060173_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_en,
    input  logic             retire,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // register samples the values from before the edge regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (run_en) cycle_cnt <= cycle_cnt + 1'b1;
            if (retire) instret_cnt <= instret_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ysyx_25060173_core_ctrl.sv
// Multi-cycle sequencer: IF -> ID -> EX -> (MEM) -> WB, with memory watchdog,
// sticky halt reporting and performance counters.
module ysyx_25060173_core_ctrl
    import ysyx_25060173_ctrl_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    input  logic             imem_rvalid,
    output logic             ir_we,
    input  logic             dec_legal,
    input  logic             dec_load,
    input  logic             dec_store,
    input  logic             dec_ebreak,
    input  logic             dec_rd_we,
    output logic             dmem_req,
    output logic             dmem_wen,
    input  logic             dmem_done,
    output logic             pc_we,
    output logic             rf_we,
    output logic             halt,
    output logic [1:0]       halt_code,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    localparam int             WD_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_e          state, state_nxt;
    logic [1:0]      code_q, code_nxt;
    logic [WD_W-1:0] wd_cnt;
    logic            wd_expire;
    logic            rf_wb_q;
    logic            retire;

    assign wd_expire = (wd_cnt == WD_LAST);

    // NOTE: every variable written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        code_nxt  = code_q;
        retire    = 1'b0;
        case (state)
            S_IDLE: state_nxt = S_IF;
            S_IF: begin
                if (imem_rvalid) begin
                    state_nxt = S_ID;
                end else if (wd_expire) begin
                    state_nxt = S_HALT;
                    code_nxt  = HALT_TIMEOUT;
                end
            end
            S_ID: state_nxt = S_EX;
            S_EX: begin
                if (!dec_legal) begin
                    state_nxt = S_HALT;
                    code_nxt  = HALT_ILLEGAL;
                end else if (dec_ebreak) begin
                    state_nxt = S_HALT;
                    code_nxt  = HALT_EBREAK;
                    retire    = 1'b1;
                end else if (dec_load || dec_store) begin
                    state_nxt = S_MEM;
                end else begin
                    state_nxt = S_WB;
                end
            end
            S_MEM: begin
                if (dmem_done) begin
                    state_nxt = S_WB;
                end else if (wd_expire) begin
                    state_nxt = S_HALT;
                    code_nxt  = HALT_TIMEOUT;
                end
            end
            S_WB: begin
                state_nxt = S_IF;
                retire    = 1'b1;
            end
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            code_q  <= HALT_NONE;
            wd_cnt  <= '0;
            rf_wb_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            code_q <= code_nxt;
            // Any state change restarts the watchdog, so each IF/MEM visit starts from zero.
            if (state_nxt != state) begin
                wd_cnt <= '0;
            end else if (state == S_IF || state == S_MEM) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            // Writeback qualifier is captured in EX, where decoder flags are defined as valid.
            if (state == S_EX) begin
                rf_wb_q <= dec_rd_we & ~dec_store;
            end
        end
    end

    assign imem_req  = (state == S_IF);
    assign ir_we     = (state == S_IF) & imem_rvalid;
    assign dmem_req  = (state == S_MEM);
    assign dmem_wen  = (state == S_MEM) & dec_store;
    assign pc_we     = (state == S_WB);
    assign rf_we     = (state == S_WB) & rf_wb_q;
    assign halt      = (state == S_HALT);
    assign halt_code = code_q;

    ysyx_25060173_perf_counters #(
        .CNT_W(CNT_W)
    ) u_perf (
        .clk        (clk),
        .rst_n      (rst_n),
        .run_en     (state != S_HALT),
        .retire     (retire),
        .cycle_cnt  (cycle_cnt),
        .instret_cnt(instret_cnt)
    );

endmodule

// File: tb/tb_ysyx_25060173_core_ctrl.sv
// Self-checking bench: builds a per-cycle expected trace from an instruction-level
// timeline model, drives it into the controller and compares every cycle.
module tb_ysyx_25060173_core_ctrl;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req, imem_rvalid, ir_we;
    logic        dec_legal, dec_load, dec_store, dec_ebreak, dec_rd_we;
    logic        dmem_req, dmem_wen, dmem_done;
    logic        pc_we, rf_we, halt;
    logic [1:0]  halt_code;
    logic [31:0] cycle_cnt, instret_cnt;

    always #5 clk = ~clk;

    ysyx_25060173_core_ctrl #(.CNT_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_rvalid(imem_rvalid), .ir_we(ir_we),
        .dec_legal(dec_legal), .dec_load(dec_load), .dec_store(dec_store),
        .dec_ebreak(dec_ebreak), .dec_rd_we(dec_rd_we),
        .dmem_req(dmem_req), .dmem_wen(dmem_wen), .dmem_done(dmem_done),
        .pc_we(pc_we), .rf_we(rf_we), .halt(halt), .halt_code(halt_code),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    typedef enum {K_ALU, K_BR, K_LW, K_SW, K_EBREAK, K_ILL} kind_e;

    typedef struct {
        logic        rvalid, done, legal, load, store, ebreak, rd_we;
        logic [8:0]  exp_out;
        logic [31:0] exp_cyc, exp_inst;
    } rec_t;

    rec_t        plan[$];
    int          m_cyc, m_inst;
    bit          m_halted;
    logic [1:0]  m_code;
    logic        cur_legal, cur_load, cur_store, cur_ebreak, cur_rd;
    int          tests = 0, fails = 0;
    logic [8:0]  log_out[0:63];
    logic [31:0] log_cyc[0:63], log_inst[0:63];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Output vector layout: imem_req ir_we dmem_req dmem_wen pc_we rf_we halt code[1:0]
    function automatic logic [8:0] mk(logic ireq, logic irw, logic dreq, logic dwen,
                                      logic pcw, logic rfw, logic h, logic [1:0] c);
        return {ireq, irw, dreq, dwen, pcw, rfw, h, c};
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic rv, input logic dn, input logic [8:0] o);
        rec_t r;
        r.rvalid = rv; r.done = dn;
        r.legal = cur_legal; r.load = cur_load; r.store = cur_store;
        r.ebreak = cur_ebreak; r.rd_we = cur_rd;
        r.exp_out = o; r.exp_cyc = m_cyc; r.exp_inst = m_inst;
        plan.push_back(r);
        if (!m_halted) m_cyc++;
    endtask

    task automatic model_reset();
        plan.delete();
        m_cyc = 0; m_inst = 0; m_halted = 0; m_code = 2'b00;
        {cur_legal, cur_load, cur_store, cur_ebreak, cur_rd} = 5'($urandom);
        push(rnd(), rnd(), 9'd0);
    endtask

    task automatic halt_tail(input int n);
        for (int k = 0; k < n; k++) begin
            {cur_legal, cur_load, cur_store, cur_ebreak, cur_rd} = 5'($urandom);
            push(rnd(), rnd(), mk(0, 0, 0, 0, 0, 0, 1, m_code));
        end
    endtask

    // One instruction as a timeline: IF x(wi+1), ID, EX, [MEM x(wd+1)], WB.
    task automatic add_inst(input kind_e kind, input int wi, input int wd);
        if (m_halted) return;
        cur_legal = 1; cur_load = 0; cur_store = 0; cur_ebreak = 0; cur_rd = 0;
        case (kind)
            K_ALU:    cur_rd = 1;
            K_BR:     cur_rd = 0;
            K_LW:     begin cur_load = 1; cur_rd = 1; end
            K_SW:     begin cur_store = 1; cur_rd = rnd(); end
            K_EBREAK: cur_ebreak = 1;
            K_ILL:    begin cur_legal = 0; {cur_load, cur_ebreak, cur_rd} = 3'($urandom); end
            default:  ;
        endcase
        for (int k = 0; ; k++) begin
            if (k == wi) begin
                push(1, rnd(), mk(1, 1, 0, 0, 0, 0, 0, 0));
                break;
            end
            push(0, rnd(), mk(1, 0, 0, 0, 0, 0, 0, 0));
            if (k == TO - 1) begin
                m_halted = 1; m_code = 2'b11;
                return;
            end
        end
        push(rnd(), rnd(), 9'd0);
        push(rnd(), rnd(), 9'd0);
        if (kind == K_ILL) begin
            m_halted = 1; m_code = 2'b10;
            return;
        end
        if (kind == K_EBREAK) begin
            m_inst++;
            m_halted = 1; m_code = 2'b01;
            return;
        end
        if (cur_load || cur_store) begin
            for (int k = 0; ; k++) begin
                if (k == wd) begin
                    push(rnd(), 1, mk(0, 0, 1, cur_store, 0, 0, 0, 0));
                    break;
                end
                push(rnd(), 0, mk(0, 0, 1, cur_store, 0, 0, 0, 0));
                if (k == TO - 1) begin
                    m_halted = 1; m_code = 2'b11;
                    return;
                end
            end
        end
        push(rnd(), rnd(), mk(0, 0, 0, 0, 1, cur_rd & ~cur_store, 0, 0));
        m_inst++;
    endtask

    task automatic run_plan(input int limit, input string tag);
        rst_n = 1'b0;
        {imem_rvalid, dmem_done, dec_legal, dec_load, dec_store, dec_ebreak, dec_rd_we} = '0;
        #1;
        check({tag, " reset outputs"},
              {55'd0, imem_req, ir_we, dmem_req, dmem_wen, pc_we, rf_we, halt, halt_code}, 64'd0);
        check({tag, " reset counters"}, {cycle_cnt, instret_cnt}, 64'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < limit; i++) begin
            if (i > 0) @(posedge clk);
            #2;
            imem_rvalid = plan[i].rvalid; dmem_done  = plan[i].done;
            dec_legal   = plan[i].legal;  dec_load   = plan[i].load;
            dec_store   = plan[i].store;  dec_ebreak = plan[i].ebreak;
            dec_rd_we   = plan[i].rd_we;
            #2;
            check($sformatf("%s c%0d outputs", tag, i),
                  {55'd0, imem_req, ir_we, dmem_req, dmem_wen, pc_we, rf_we, halt, halt_code},
                  {55'd0, plan[i].exp_out});
            check($sformatf("%s c%0d cycle/instret", tag, i),
                  {cycle_cnt, instret_cnt}, {plan[i].exp_cyc, plan[i].exp_inst});
            if (i < 64) begin
                log_out[i]  = {imem_req, ir_we, dmem_req, dmem_wen, pc_we, rf_we, halt, halt_code};
                log_cyc[i]  = cycle_cnt;
                log_inst[i] = instret_cnt;
            end
        end
    endtask

    function automatic int count_bit(int b, int lo, int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++) n += int'(log_out[i][b]);
        return n;
    endfunction

    function automatic int pick_wait();
        int r = $urandom_range(0, 19);
        return (r < 14) ? r % 3 : (r < 18) ? TO - 1 : TO;
    endfunction

    initial begin
        rst_n = 1'b1;
        {imem_rvalid, dmem_done, dec_legal, dec_load, dec_store, dec_ebreak, dec_rd_we} = '0;
        #1;

        // Two addi then ebreak, zero-wait fetch.
        model_reset();
        add_inst(K_ALU, 0, 0); add_inst(K_ALU, 0, 0); add_inst(K_EBREAK, 0, 0);
        halt_tail(4);
        check("A model length", plan.size(), 16);
        run_plan(plan.size(), "A");
        check("A ir_we@1", log_out[1][7], 1);
        check("A pc_we@4", log_out[4][4], 1);
        check("A rf_we@4", log_out[4][3], 1);
        check("A instret@5", log_inst[5], 1);
        check("A halt@12", log_out[12][2], 1);
        check("A code@12", log_out[12][1:0], 2'b01);
        check("A instret@12", log_inst[12], 3);
        check("A cycle@12", log_cyc[12], 12);
        check("A cycle frozen@15", log_cyc[15], 12);
        check("A imem_req@14", log_out[14][8], 0);

        // lw with 3 wait cycles, zero-wait sw, then illegal.
        model_reset();
        add_inst(K_LW, 0, 3); add_inst(K_SW, 0, 0); add_inst(K_ILL, 0, 0);
        halt_tail(4);
        check("B model length", plan.size(), 21);
        run_plan(plan.size(), "B");
        check("B lw dmem_req cycles", count_bit(6, 1, 8), 4);
        check("B lw dmem_wen@4", log_out[4][5], 0);
        check("B lw rf_we@8", log_out[8][3], 1);
        check("B sw dmem_wen@12", log_out[12][5], 1);
        check("B sw rf_we@13", log_out[13][3], 0);
        check("B sw pc_we@13", log_out[13][4], 1);
        check("B illegal code@17", log_out[17][1:0], 2'b10);
        check("B no pc_we after sw", count_bit(4, 14, 20), 0);
        check("B instret@17", log_inst[17], 2);

        // Fetch never answered: watchdog timeout.
        model_reset();
        add_inst(K_ALU, TO, 0);
        halt_tail(4);
        run_plan(plan.size(), "C");
        check("C imem_req@8", log_out[8][8], 1);
        check("C halt@8", log_out[8][2], 0);
        check("C code@9", log_out[9][1:0], 2'b11);
        check("C cycle@9", log_cyc[9], TO + 1);
        check("C no ir_we", count_bit(7, 1, TO), 0);

        // Stop inside MEM; the next run's reset lands mid-request.
        model_reset();
        add_inst(K_LW, 0, 3);
        run_plan(6, "D");
        check("D dmem_req before reset", log_out[5][6], 1);

        // Randomized programs.
        for (int r = 0; r < 30; r++) begin
            int n = $urandom_range(3, 10);
            model_reset();
            for (int k = 0; k < n; k++) begin
                int s = $urandom_range(0, 19);
                kind_e kd = (s < 6) ? K_ALU : (s < 8) ? K_BR : (s < 12) ? K_LW :
                            (s < 17) ? K_SW : (s < 19) ? K_EBREAK : K_ILL;
                add_inst(kd, pick_wait(), pick_wait());
            end
            if (m_halted) halt_tail(3);
            run_plan(plan.size(), $sformatf("R%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ysyx_25060173_core_ctrl.md
# ysyx_25060173_core_ctrl

Multi-cycle sequencing controller for the NPC core. It consumes the one-hot instruction flags from the instruction decoder and steps the core through fetch, decode, execute, memory and writeback. It drives instruction/data memory request handshakes and the PC, IR and register-file write enables. It also detects halt conditions (ebreak, illegal instruction, memory timeout) and maintains cycle/instret performance counters.

## Interface
Parameters:
- CNT_W, 32, width of cycle and instret counters
- TIMEOUT, 256, max cycles waiting for a memory response before bus-timeout halt (≥2)

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  instruction fetch request, level, held until response
- imem_rvalid  in  1  instruction data valid this cycle
- ir_we  out  1  latch fetched instruction into IR
- dec_legal  in  1  OR of all decoder flags (any recognised instruction)
- dec_load  in  1  inst_lw
- dec_store  in  1  inst_sw
- dec_ebreak  in  1  inst_ebreak
- dec_rd_we  in  1  instruction writes rd (not store, not branch)
- dmem_req  out  1  data memory request, level, held until done
- dmem_wen  out  1  store qualifier, valid only with dmem_req
- dmem_done  in  1  data access complete this cycle
- pc_we  out  1  commit next PC
- rf_we  out  1  commit rd write
- halt  out  1  sticky, core stopped
- halt_code  out  2  00 none, 01 ebreak, 10 illegal, 11 bus timeout
- cycle_cnt  out  CNT_W  cycles since reset release
- instret_cnt  out  CNT_W  retired instructions

## Operation
- States: IDLE, IF, ID, EX, MEM, WB, HALT.
- IDLE: entered on reset; next cycle always goes to IF.
- IF: imem_req=1.
  - On imem_rvalid: ir_we=1 for that cycle, then go to ID.
  - Otherwise stay in IF.
- ID: one cycle, then EX. Decoder flags are sampled only in EX.
- EX, priority order:
  - !dec_legal → HALT, code 10.
  - dec_ebreak → HALT, code 01; instret increments.
  - dec_load|dec_store → MEM.
  - Otherwise → WB.
- MEM: dmem_req=1, dmem_wen=dec_store.
  - On dmem_done → WB.
  - Otherwise stay in MEM.
- WB: one cycle. pc_we=1, rf_we=dec_rd_we&!dec_store, instret increments; then IF.
- HALT: absorbing until reset. All request/write-enable outputs are 0. cycle_cnt freezes.
- Watchdog counter:
  - Cleared on entry to IF or MEM; increments each cycle spent in IF/MEM without a response.
  - If it reaches TIMEOUT-1 with no response that cycle → HALT, code 11; no ir_we/pc_we/rf_we.
- imem_rvalid outside IF and dmem_done outside MEM are ignored.
- Counters wrap modulo 2^CNT_W.
- halt_code is written only on the HALT transition and held.

## Timing
- Reset (async assert): state=IDLE; every output 0, including counters, halt and halt_code.
- Release is synchronous to the next clk edge.
- All outputs are registered or decoded from state only. No combinational input→output paths except:
  - ir_we = (state==IF)&imem_rvalid.
  - dmem_wen follows dec_store while in MEM.
- Zero-wait memory latencies:
  - ALU/branch/jal instruction: IF→ID→EX→WB = 4 cycles.
  - lw/sw: 5 cycles.
  - Each memory wait cycle adds 1.
- cycle_cnt increments every cycle from the first post-reset edge until HALT is entered. It does not increment in HALT.
- instret_cnt updates on the edge leaving WB, or leaving EX for an ebreak.
- Response and timeout in the same cycle: the response wins.
- Reset mid-MEM drops dmem_req asynchronously. The memory side must tolerate an abandoned request.

## Structure
- Package ysyx_25060173_ctrl_pkg holds:
  - State enum (7 states, 3-bit encoding).
  - HALT_NONE/EBREAK/ILLEGAL/TIMEOUT 2-bit constants.
- Sub-module ysyx_25060173_perf_counters holds cycle_cnt and instret_cnt, with inputs run_en and retire.
- FSM, watchdog and output decode live in the top module.

## Test plan
- addi, zero-wait memory, from reset → ir_we at cycle 1, pc_we=rf_we=1 at cycle 4, instret_cnt=1 at cycle 5.
- lw with dmem_done after 3 wait cycles → dmem_req high 4 cycles with dmem_wen=0, rf_we=1 in WB, 8 cycles total.
- sw → dmem_wen=1 throughout MEM, rf_we=0, pc_we=1 in WB.
- ebreak after 2 retired addi → halt=1, halt_code=01, instret_cnt=3, cycle_cnt frozen, imem_req stays 0.
- dec_legal=0 in EX → halt_code=10, no pc_we. Separately, imem_rvalid never asserted with TIMEOUT=8 → halt_code=11 after 8 IF cycles.
- rst_n pulsed low mid-MEM → outputs 0 immediately, counters 0, restart at IDLE→IF.
